// File: rtl/mdu_iter_if.sv
// Handshake/result bundle between the E-stage and the iterative multiply/divide unit.
// Launch/cancel/direct-write controls in, HI/LO/Busy/Done out; Start is ignored while Busy.
interface mdu_iter_if #(parameter int WIDTH = 32);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic             Cancel;
    logic             HI_En;
    logic             LO_En;
    logic [WIDTH-1:0] WrHL;
    logic [WIDTH-1:0] R_HI;
    logic [WIDTH-1:0] R_LO;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Op, D1, D2, Cancel, HI_En, LO_En, WrHL,
        input  R_HI, R_LO, Busy, Done
    );

    modport slave (
        input  Start, Op, D1, D2, Cancel, HI_En, LO_En, WrHL,
        output R_HI, R_LO, Busy, Done
    );
endinterface

// File: rtl/mdu_iter.sv
// Radix-2 iterative mul/div/madd/msub with HI/LO: WIDTH+1 busy cycles, Done the cycle after the write.
// No backpressure: Start is dropped while Busy, Cancel aborts without touching HI/LO.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic         Clk,
    input  logic         Rst,
    mdu_iter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opb;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;      // MUL: {partial, multiplier}; DIV: {remainder, quotient}
    logic               neg_q;
    logic               neg_r;
    logic               dz;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               is_signed;
    logic               is_div;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] hilo;
    logic [2*WIDTH-1:0] mac;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    always_comb begin
        is_signed = ~bus.Op[0];
        is_div    = (bus.Op[2:1] == 2'b01);
        a_mag     = (is_signed && bus.D1[WIDTH-1]) ? -bus.D1 : bus.D1;
        b_mag     = (is_signed && bus.D2[WIDTH-1]) ? -bus.D2 : bus.D2;

        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb};

        prod  = neg_q ? -acc : acc;
        hilo  = {hi_q, lo_q};
        mac   = op_q[1] ? (hilo - prod) : (hilo + prod);
        // A zero divisor leaves an all-ones quotient; force it so the sign fixup cannot disturb it.
        q_fix = dz ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        r_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            opb    <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.HI_En) hi_q <= bus.WrHL;
            if (bus.LO_En) lo_q <= bus.WrHL;

            if (state != IDLE && bus.Cancel) begin
                state  <= IDLE;
                cnt    <= '0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.Start && !bus.Cancel) begin
                            op_q   <= bus.Op;
                            neg_q  <= is_signed & (bus.D1[WIDTH-1] ^ bus.D2[WIDTH-1]);
                            neg_r  <= is_signed & bus.D1[WIDTH-1];
                            dz     <= (bus.D2 == '0);
                            cnt    <= CNT_W'(WIDTH);
                            busy_q <= 1'b1;
                            if (is_div) begin
                                acc   <= {{WIDTH{1'b0}}, a_mag};
                                opb   <= b_mag;
                                state <= DIV;
                            end else begin
                                acc   <= {{WIDTH{1'b0}}, b_mag};
                                opb   <= a_mag;
                                state <= MUL;
                            end
                        end
                    end
                    MUL: begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= FIX;
                    end
                    DIV: begin
                        if (div_diff[WIDTH+1])
                            acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                        else
                            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= FIX;
                    end
                    FIX: begin
                        // Placed after the direct-write updates so the result wins per register.
                        if (op_q[2:1] == 2'b01) begin
                            lo_q <= q_fix;
                            hi_q <= r_fix;
                        end else if (!op_q[2]) begin
                            {hi_q, lo_q} <= prod;
                        end else begin
                            {hi_q, lo_q} <= mac;
                        end
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.R_HI = hi_q;
    assign bus.R_LO = lo_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter at WIDTH=32 and WIDTH=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mdu_iter;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   dn;

    always #5 Clk = ~Clk;

    mdu_iter_if #(.WIDTH(32)) b32 ();
    mdu_iter_if #(.WIDTH(8))  b8 ();

    mdu_iter #(.WIDTH(32)) dut32 (.Clk(Clk), .Rst(Rst), .bus(b32));
    mdu_iter #(.WIDTH(8))  dut8  (.Clk(Clk), .Rst(Rst), .bus(b8));

    // Caller sits at a falling edge; returns at the falling edge of busy cycle 1.
    task automatic launch32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        b32.Start = 1'b1; b32.Op = op; b32.D1 = a; b32.D2 = b;
        @(negedge Clk);
        b32.Start = 1'b0;
    endtask

    task automatic wait_idle32();
        cyc = 0; dn = 0;
        while (b32.Busy === 1'b1 && cyc < 200) begin
            if (b32.Done === 1'b1) dn++;
            cyc++;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        b32.Start = 0; b32.Op = 0; b32.D1 = 0; b32.D2 = 0; b32.Cancel = 0;
        b32.HI_En = 0; b32.LO_En = 0; b32.WrHL = 0;
        b8.Start = 0; b8.Op = 0; b8.D1 = 0; b8.D2 = 0; b8.Cancel = 0;
        b8.HI_En = 0; b8.LO_En = 0; b8.WrHL = 0;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        checks++; if (b32.R_HI !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", b32.R_HI); end
        checks++; if (b32.R_LO !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", b32.R_LO); end
        checks++; if (b32.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b32.Busy); end
        checks++; if (b32.Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", b32.Done); end
    endtask

    task automatic test_mult();
        launch32(3'b000, 32'hFFFF_FFFE, 32'd3);
        wait_idle32();
        checks++; if (cyc != 33) begin errors++; $display("FAIL mult_busy_cycles got %0d want 33", cyc); end
        checks++; if (b32.Done !== 1'b1 || dn != 0) begin errors++; $display("FAIL mult_done got %b early %0d want 1 early 0", b32.Done, dn); end
        checks++; if (b32.R_HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", b32.R_HI); end
        checks++; if (b32.R_LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", b32.R_LO); end
        @(negedge Clk);
        checks++; if (b32.Done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", b32.Done); end
        launch32(3'b001, 32'hFFFF_FFFE, 32'd3);
        wait_idle32();
        checks++; if (b32.R_HI !== 32'h2) begin errors++; $display("FAIL multu_hi got %h want 00000002", b32.R_HI); end
        checks++; if (b32.R_LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got %h want fffffffa", b32.R_LO); end
    endtask

    task automatic test_div();
        logic [2:0]  ops [7] = '{3'b011, 3'b010, 3'b010, 3'b010, 3'b011, 3'b010, 3'b010};
        logic [31:0] d1s [7] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000};
        logic [31:0] d2s [7] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] elo [7] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] ehi [7] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'd0};
        for (int i = 0; i < 7; i++) begin
            launch32(ops[i], d1s[i], d2s[i]);
            wait_idle32();
            checks++; if (cyc != 33 || b32.Done !== 1'b1) begin errors++; $display("FAIL div%0d_latency got %0d done %b want 33 done 1", i, cyc, b32.Done); end
            checks++; if (b32.R_LO !== elo[i]) begin errors++; $display("FAIL div%0d_lo got %h want %h", i, b32.R_LO, elo[i]); end
            checks++; if (b32.R_HI !== ehi[i]) begin errors++; $display("FAIL div%0d_hi got %h want %h", i, b32.R_HI, ehi[i]); end
        end
    endtask

    task automatic test_madd();
        b32.HI_En = 1; b32.LO_En = 1; b32.WrHL = 32'h5A5A_0001;
        @(negedge Clk);
        b32.HI_En = 0; b32.LO_En = 0;
        checks++; if (b32.R_HI !== 32'h5A5A_0001 || b32.R_LO !== 32'h5A5A_0001) begin errors++; $display("FAIL mt_both got %h/%h want 5a5a0001/5a5a0001", b32.R_HI, b32.R_LO); end
        b32.HI_En = 1; b32.WrHL = 32'h0;
        @(negedge Clk);
        b32.HI_En = 0; b32.LO_En = 1; b32.WrHL = 32'hFFFF_FFFF;
        @(negedge Clk);
        b32.LO_En = 0;
        checks++; if (b32.R_HI !== 32'h0 || b32.R_LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mt_preload got %h/%h want 00000000/ffffffff", b32.R_HI, b32.R_LO); end
        launch32(3'b101, 32'd1, 32'd1);
        wait_idle32();
        checks++; if (b32.R_HI !== 32'h1 || b32.R_LO !== 32'h0) begin errors++; $display("FAIL maddu got %h/%h want 00000001/00000000", b32.R_HI, b32.R_LO); end
        launch32(3'b110, 32'd1, 32'd2);
        wait_idle32();
        checks++; if (b32.R_HI !== 32'h0 || b32.R_LO !== 32'hFFFF_FFFE) begin errors++; $display("FAIL msub got %h/%h want 00000000/fffffffe", b32.R_HI, b32.R_LO); end
    endtask

    task automatic test_back_to_back();
        launch32(3'b000, 32'd2, 32'd3);
        @(negedge Clk);
        b32.Start = 1; b32.Op = 3'b001; b32.D1 = 32'd5; b32.D2 = 32'd7;
        b32.HI_En = 1; b32.WrHL = 32'h1234;
        @(negedge Clk);
        b32.Start = 0; b32.HI_En = 0;
        checks++; if (b32.R_HI !== 32'h1234 || b32.Busy !== 1'b1) begin errors++; $display("FAIL mthi_midflight got %h busy %b want 00001234 busy 1", b32.R_HI, b32.Busy); end
        wait_idle32();
        checks++; if (cyc != 31 || b32.Done !== 1'b1) begin errors++; $display("FAIL ignored_start_latency got %0d done %b want 31 done 1", cyc, b32.Done); end
        checks++; if (b32.R_HI !== 32'h0 || b32.R_LO !== 32'd6) begin errors++; $display("FAIL ignored_start got %h/%h want 00000000/00000006", b32.R_HI, b32.R_LO); end
        // Relaunch in the Done cycle, then collide a direct LO write with the result write.
        launch32(3'b001, 32'd4, 32'd5);
        repeat (32) @(negedge Clk);
        checks++; if (b32.Busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", b32.Busy); end
        b32.LO_En = 1; b32.WrHL = 32'hAAAA;
        @(negedge Clk);
        b32.LO_En = 0;
        checks++; if (b32.Busy !== 1'b0 || b32.Done !== 1'b1) begin errors++; $display("FAIL b2b_done got busy %b done %b want 0 1", b32.Busy, b32.Done); end
        checks++; if (b32.R_HI !== 32'h0 || b32.R_LO !== 32'd20) begin errors++; $display("FAIL fix_wins got %h/%h want 00000000/00000014", b32.R_HI, b32.R_LO); end
    endtask

    task automatic test_cancel();
        launch32(3'b010, 32'd100, 32'd7);
        repeat (9) @(negedge Clk);
        b32.Cancel = 1;
        @(negedge Clk);
        b32.Cancel = 0;
        checks++; if (b32.Busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b want 0", b32.Busy); end
        checks++; if (b32.R_HI !== 32'h0 || b32.R_LO !== 32'd20) begin errors++; $display("FAIL cancel_hilo got %h/%h want 00000000/00000014", b32.R_HI, b32.R_LO); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (b32.Done === 1'b1) dn++;
            @(negedge Clk);
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL cancel_no_done got %0d want 0", dn); end
        b32.Start = 1; b32.Cancel = 1; b32.Op = 3'b011; b32.D1 = 32'd9; b32.D2 = 32'd3;
        @(negedge Clk);
        b32.Start = 0; b32.Cancel = 0;
        checks++; if (b32.Busy !== 1'b0) begin errors++; $display("FAIL start_cancel_busy got %b want 0", b32.Busy); end
        @(negedge Clk);
        checks++; if (b32.Busy !== 1'b0) begin errors++; $display("FAIL start_cancel_busy2 got %b want 0", b32.Busy); end
    endtask

    task automatic test_width8();
        int c8;
        b8.Start = 1; b8.Op = 3'b001; b8.D1 = 8'hFF; b8.D2 = 8'hFF;
        @(negedge Clk);
        b8.Start = 0;
        c8 = 0;
        while (b8.Busy === 1'b1 && c8 < 100) begin
            c8++;
            @(negedge Clk);
        end
        checks++; if (c8 != 9 || b8.Done !== 1'b1) begin errors++; $display("FAIL w8_latency got %0d done %b want 9 done 1", c8, b8.Done); end
        checks++; if (b8.R_HI !== 8'hFE || b8.R_LO !== 8'h01) begin errors++; $display("FAIL w8_multu got %h/%h want fe/01", b8.R_HI, b8.R_LO); end
    endtask

    task automatic test_reset_mid();
        launch32(3'b001, 32'd5, 32'd5);
        repeat (4) @(negedge Clk);
        Rst = 1;
        @(negedge Clk);
        Rst = 0;
        checks++; if (b32.R_HI !== 32'h0 || b32.R_LO !== 32'h0 || b32.Busy !== 1'b0) begin errors++; $display("FAIL reset_mid got %h/%h busy %b want 0/0 busy 0", b32.R_HI, b32.R_LO, b32.Busy); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (b32.Done === 1'b1) dn++;
            @(negedge Clk);
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL reset_mid_no_done got %0d want 0", dn); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_madd();
        test_back_to_back();
        test_cancel();
        test_width8();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
